// File: rtl/regression_controller.sv
// regression_controller: sequences clear, accumulate, mean and coefficient loads of the regression datapath
module regression_controller #(
  parameter int N_SAMPLES = 150,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             en,
  output logic             clr_sumx,
  output logic             clr_sumy,
  output logic             clr_sumxy,
  output logic             clr_sumxx,
  output logic             clr_meanx,
  output logic             clr_meany,
  output logic             clr_B0,
  output logic             clr_B1,
  output logic             ld_sumx,
  output logic             ld_sumy,
  output logic             ld_sumxy,
  output logic             ld_sumxx,
  output logic             ld_meanx,
  output logic             ld_meany,
  output logic             ld_B0,
  output logic             ld_B1,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt
);
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, MEAN, COEF, DONE} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fire, clr_all, ld_sum, ld_mean, ld_coef;
  // abort withholds in_ready so no pair is consumed on the way out
  always_comb begin
    in_ready = (state_q == ACCUM) && !abort;
    fire     = in_ready && in_valid;
    busy     = state_q != IDLE;
    en       = busy;
    done     = state_q == DONE;
    clr_all  = state_q == CLEAR;
    ld_sum   = fire;
    ld_mean  = state_q == MEAN;
    ld_coef  = state_q == COEF;
    {clr_sumx, clr_sumy, clr_sumxy, clr_sumxx} = {4{clr_all}};
    {clr_meanx, clr_meany, clr_B0, clr_B1}     = {4{clr_all}};
    {ld_sumx, ld_sumy, ld_sumxy, ld_sumxx}     = {4{ld_sum}};
    {ld_meanx, ld_meany}                       = {2{ld_mean}};
    {ld_B0, ld_B1}                             = {2{ld_coef}};
    sample_cnt = cnt_q;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = fire ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      IDLE:    state_d = (start && !abort) ? CLEAR : IDLE;
      CLEAR:   begin state_d = ACCUM; cnt_d = '0; end
      ACCUM:   state_d = (fire && cnt_q == CNT_W'(N_SAMPLES - 1)) ? MEAN : ACCUM;
      MEAN:    state_d = COEF;
      COEF:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/regression_controller.md
Name: regression_controller

Overview:
- Control FSM that sequences the linear-regression coefficient datapath.
- Clears the datapath accumulators, then accepts exactly N_SAMPLES (x,y) pairs over a valid/ready handshake, driving ld_sumx/ld_sumy/ld_sumxy/ld_sumxx once per accepted pair.
- Then loads the means, then loads B1/B0, then reports done.
- Sits between the sample source (memory reader or FIFO) and the coefficient datapath; it drives every ld_*/clr_*/en control of that datapath.

Parameters:
- N_SAMPLES, 150, number of (x,y) pairs per regression run; must match the datapath's fixed divide-by-N.
- CNT_W, 8, sample counter width; must satisfy 2^CNT_W > N_SAMPLES.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE
- abort  input  1  cancel the run in progress; return to IDLE with no done
- in_valid  input  1  source presents a valid (x,y) pair this cycle
- in_ready  output  1  controller accepts a pair this cycle
- en  output  1  datapath enable; high in every state except IDLE
- clr_sumx, clr_sumy, clr_sumxy, clr_sumxx  output  1 each  accumulator clears
- clr_meanx, clr_meany, clr_B0, clr_B1  output  1 each  result register clears
- ld_sumx, ld_sumy, ld_sumxy, ld_sumxx  output  1 each  accumulate current pair
- ld_meanx, ld_meany  output  1 each  capture means
- ld_B0, ld_B1  output  1 each  capture coefficients
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when B0/B1 are valid
- sample_cnt  output  CNT_W  number of pairs accepted in the current run

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE and sample_cnt to 0. Every output is 0, including in_ready, done, busy, en and all ld_*/clr_*.
- Reset has priority over abort. abort has priority over all other transitions.
- States: IDLE, CLEAR, ACCUM, MEAN, COEF, DONE.
- IDLE: all outputs 0. If start=1, go to CLEAR next cycle. sample_cnt holds its last value, so the count of the finished run stays readable.
- CLEAR: one cycle. All eight clr_* = 1. sample_cnt is set to 0. Next state is ACCUM.
- ACCUM: in_ready=1.
  - Handshake fires when in_valid & in_ready. In that same cycle (combinational from in_valid), ld_sumx = ld_sumy = ld_sumxy = ld_sumxx = 1, and sample_cnt increments.
  - If in_valid=0: no ld_*, counter holds. Stalls of any length are allowed.
  - When the handshake fires with sample_cnt == N_SAMPLES-1: sample_cnt becomes N_SAMPLES, next state is MEAN, and in_ready is 0 from the next cycle. No extra pair is ever accepted.
- MEAN: one cycle. ld_meanx = ld_meany = 1. Next state is COEF.
- COEF: one cycle. ld_B1 = ld_B0 = 1. Means are now registered, so the combinational B1/B0 paths are settled. Next state is DONE.
- DONE: one cycle. done=1, busy=1. Next state is IDLE. start is not sampled in DONE; a new run requires start in IDLE.
- Output timing: all ld_*/clr_*/done are pure functions of state (plus in_valid for the ACCUM lds). At most one group of ld_* is active per cycle; clr_* are never asserted together with any ld_*.
- Latency: start sampled in IDLE at cycle t gives CLEAR at t+1 and ACCUM from t+2. With in_valid held at 1, the N accepts land in cycles t+2 .. t+N+1, MEAN at t+N+2, COEF at t+N+3, and the done pulse at t+N+4.
- start while busy: ignored.
- start and abort both high in IDLE: stay in IDLE.
- abort in any non-IDLE state: next cycle is IDLE with all outputs 0.
  - No ld_* is asserted in the abort cycle: abort gates in_ready, so no handshake occurs.
  - sample_cnt holds the partial count.
- rst mid-run: same as power-on reset. The next run starts with CLEAR, so stale accumulator contents never leak.
- sample_cnt: saturating by construction (never exceeds N_SAMPLES), never wraps.

Test Plan:
- N_SAMPLES=4; start pulse, in_valid held 1. Expect clr_* in cycle t+1 and ld_sum* in t+2..t+5. Expect ld_mean* at t+6, ld_B0/B1 at t+7 and done at t+8. sample_cnt=4, in_ready=0 after t+5.
- N_SAMPLES=4; in_valid toggles 1,0,0,1,0,1,1. Expect ld_sum* exactly on the four valid cycles, sample_cnt steps 1..4, and done 3 cycles after the 4th accept.
- Default N=150, pairs x=i, y=2i+3 (i=1..150) with random stalls against the real datapath. Expect done once, B1 = 2.0 and B0 = 3.0 in the datapath fixed-point format, and exactly 150 ld_sumx pulses.
- abort asserted after 2 accepts (N=4). Expect next cycle IDLE, busy=0, no done, and sample_cnt=2. A new start then shows CLEAR and sample_cnt=0.
- rst asserted during MEAN. Expect next cycle all outputs 0 and sample_cnt=0; start pulses while busy (during ACCUM) produce no state change.
- start and abort both high in IDLE: stays in IDLE. start held high continuously: back-to-back runs separated by exactly one IDLE cycle after each done.
